// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and defaults for the UART transmit/receive pair.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 100 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS_DEF    = 8;

  // Transmitter frame phases
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled,
//               wraps to 0 and flags bit_end in the last cycle of each bit.
//               A clear restarts the bit period from cycle 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] bit_cnt_clk;

  // Last cycle of the current bit period
  assign bit_end = enable && (bit_cnt_clk == CNT_LAST);

  // Cycle counter within a bit, explicit wrap at bit end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_clk <= '0;
    end else if (clear) begin
      bit_cnt_clk <= '0;
    end else if (bit_end) begin
      bit_cnt_clk <= '0;
    end else if (enable) begin
      bit_cnt_clk <= bit_cnt_clk + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART serial transmitter. Pops bytes from a show-ahead FIFO and
//               sends start bit, DATA_BITS LSB-first, optional parity and
//               STOP_BITS stop bits on a registered tx line. A byte waiting at
//               the end of the last stop bit is popped in that same cycle so
//               consecutive frames run with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int               IDX_W         = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);
  localparam logic             PARITY_INIT   = (PARITY_ODD != 0);

  uart_tx_state_e       state;
  uart_tx_state_e       state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 parity_bit;
  logic                 parity_next;
  logic                 busy_next;
  logic                 tx_next;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_next;
  logic                 bit_end;
  logic                 last_stop;

  // Bit timing runs in every phase except IDLE; a pop restarts the period
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (fifo_rd_en),
    .enable (state != IDLE),
    .bit_end(bit_end)
  );

  // Final cycle of the final stop bit: the only in-frame pop opportunity
  assign last_stop = (state == STOP) && bit_end && (bit_idx == LAST_STOP_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, datapath next values, pop strobe and done pulse
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    parity_next  = parity_bit;
    busy_next    = busy;
    bit_idx_next = bit_idx;
    fifo_rd_en   = 1'b0;
    tx_done      = 1'b0;
    tx_next      = 1'b1;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == LAST_DATA_IDX) begin
            bit_idx_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next   = STOP;
          bit_idx_next = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx == LAST_STOP_IDX) begin
            tx_done      = 1'b1;
            bit_idx_next = '0;
            busy_next    = 1'b0;
            state_next   = IDLE;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Pop overrides the end-of-frame return to IDLE so frames abut.
    // rst_n gates the strobe because IDLE is also the reset state.
    if (rst_n && !fifo_empty && ((state == IDLE) || last_stop)) begin
      fifo_rd_en   = 1'b1;
      shift_next   = fifo_rd_data;
      parity_next  = (^fifo_rd_data) ^ PARITY_INIT;
      busy_next    = 1'b1;
      bit_idx_next = '0;
      state_next   = START;
    end

    // Line level for the coming cycle, registered so tx never glitches
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

  // Datapath registers: shift register, parity, bit index, busy and tx line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      bit_idx    <= '0;
      busy       <= 1'b0;
      tx         <= 1'b1;
    end else begin
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      bit_idx    <= bit_idx_next;
      busy       <= busy_next;
      tx         <= tx_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx. Four instances share
//               one clock and reset: 8N1, 8E1, 8O1 and 8N2, all at 4 clocks
//               per bit. Expected frames are hand-computed bit vectors where
//               bit i is the i-th level sent on tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int NCFG = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCFG-1:0] fifo_empty;
  logic [NCFG-1:0] fifo_rd_en;
  logic [NCFG-1:0] tx;
  logic [NCFG-1:0] busy;
  logic [NCFG-1:0] tx_done;
  logic [7:0]      fifo_rd_data [NCFG];

  int              vec_cnt = 0;
  int              err_cnt = 0;

  // Per-run FIFO contents and the expected tx levels of each frame
  logic [7:0]      q_data  [2];
  logic [15:0]     q_frame [2];

  always #5 clk = ~clk;

  // 0: 8N1   1: 8E1   2: 8O1   3: 8N2
  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_empty  (fifo_empty[g]),
      .fifo_rd_data(fifo_rd_data[g]),
      .fifo_rd_en  (fifo_rd_en[g]),
      .tx          (tx[g]),
      .busy        (busy[g]),
      .tx_done     (tx_done[g])
    );
  end

  task automatic check(input string tag, input logic got, input logic exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Idle line on every instance
  task automatic check_all_idle(input string tag);
    for (int k = 0; k < NCFG; k++) begin
      check({tag, "_tx"},    tx[k],         1'b1);
      check({tag, "_busy"},  busy[k],       1'b0);
      check({tag, "_rd_en"}, fifo_rd_en[k], 1'b0);
      check({tag, "_done"},  tx_done[k],    1'b0);
    end
  endtask

  // Send n queued bytes on instance k, nb bit periods per frame, checking
  // every cycle from the pop to the first idle cycle afterwards
  task automatic run_frames(input int k, input int n, input int nb);
    int   idx;
    logic last;
    @(negedge clk);
    fifo_rd_data[k] = q_data[0];
    fifo_empty[k]   = 1'b0;
    #1;
    check("pop_first", fifo_rd_en[k], 1'b1);
    idx = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      idx++;
      if (idx < n) fifo_rd_data[k] = q_data[idx];
      else         fifo_empty[k]   = 1'b1;
      for (int c = 1; c <= nb * CPB; c++) begin
        @(negedge clk);
        last = (c == nb * CPB);
        check("tx_bit",  tx[k],         q_frame[i][(c - 1) / CPB]);
        check("busy",    busy[k],       1'b1);
        check("tx_done", tx_done[k],    last);
        check("rd_en",   fifo_rd_en[k], last && (i + 1 < n));
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("end_tx",    tx[k],         1'b1);
    check("end_busy",  busy[k],       1'b0);
    check("end_rd_en", fifo_rd_en[k], 1'b0);
    check("end_done",  tx_done[k],    1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    fifo_empty = '1;
    for (int k = 0; k < NCFG; k++) fifo_rd_data[k] = 8'h00;

    // Reset state, including pop strobe held low under reset
    repeat (3) @(negedge clk);
    check_all_idle("rst");
    rst_n = 1'b1;

    // Empty FIFO: line stays idle
    repeat (100) begin
      @(negedge clk);
      check_all_idle("idle");
    end

    // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
    q_data[0] = 8'hA5; q_frame[0] = 16'h034A;
    run_frames(0, 1, 10);

    // 0xA5 8E1: parity 0
    q_frame[0] = 16'h054A;
    run_frames(1, 1, 11);

    // 0xA5 8O1: parity 1
    q_frame[0] = 16'h074A;
    run_frames(2, 1, 11);

    // 0x00 then 0xFF back to back
    q_data[0] = 8'h00; q_frame[0] = 16'h0200;
    q_data[1] = 8'hFF; q_frame[1] = 16'h03FE;
    run_frames(0, 2, 10);

    // 0x3C 8N2: 8 stop cycles
    q_data[0] = 8'h3C; q_frame[0] = 16'h0678;
    run_frames(3, 1, 11);

    // Async reset during data bit 3 of 0x5A (cycles 17..20 after the pop)
    @(negedge clk);
    fifo_rd_data[0] = 8'h5A;
    fifo_empty[0]   = 1'b0;
    @(posedge clk);
    #1;
    fifo_empty[0] = 1'b1;
    repeat (18) @(negedge clk);
    check("mid_busy", busy[0], 1'b1);
    check("mid_tx",   tx[0],   1'b1);
    fifo_rd_data[0] = 8'h81;
    fifo_empty[0]   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx",    tx[0],         1'b1);
    check("arst_busy",  busy[0],       1'b0);
    check("arst_rd_en", fifo_rd_en[0], 1'b0);
    check("arst_done",  tx_done[0],    1'b0);
    @(negedge clk);
    check("arst_hold_rd_en", fifo_rd_en[0], 1'b0);
    fifo_empty[0] = 1'b1;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_all_idle("post_rst");
    end

    // Clean frame of 0x81 after reset
    q_data[0] = 8'h81; q_frame[0] = 16'h0302;
    run_frames(0, 1, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
